// File: rtl/bulk_in_packetizer.sv
// Bulk-IN packetizer: buffers one USB packet from an AXI-Stream byte source and
// streams it to the TLP on an IN grant, replaying on abort and emitting ZLPs.
module bulk_in_packetizer #(
  parameter int MAX_PACKET   = 512,
  parameter int PACKET_MODE  = 1,
  parameter int FLUSH_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tlast,
  input  logic        blk_in_xfer,
  output logic        blk_xfer_in_has_data,
  output logic [7:0]  blk_xfer_in_data,
  output logic        blk_xfer_in_data_valid,
  input  logic        blk_xfer_in_data_ready,
  output logic        blk_xfer_in_data_last,
  output logic [15:0] sent_packets
);

  localparam int AW = $clog2(MAX_PACKET);
  localparam int CW = AW + 1;
  localparam int IW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] MAX_LEN   = CW'(MAX_PACKET);
  localparam logic [IW-1:0] IDLE_LAST = IW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

  localparam logic [2:0] S_FILL     = 3'd0;
  localparam logic [2:0] S_HOLD     = 3'd1;
  localparam logic [2:0] S_SEND     = 3'd2;
  localparam logic [2:0] S_ZLP_HOLD = 3'd3;
  localparam logic [2:0] S_ZLP_MARK = 3'd4;

  logic [7:0] mem [MAX_PACKET];

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic          zlp_pend_q, zlp_pend_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic          tready_q, tready_d;
  logic          has_data_q, has_data_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic [15:0]   sent_q, sent_d;
  logic          accept, handshake, mem_we;

  // Next-state logic for fill, hold, send/replay and ZLP marker sequencing
  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    len_d      = len_q;
    rd_ptr_d   = rd_ptr_q;
    zlp_pend_d = zlp_pend_q;
    idle_cnt_d = idle_cnt_q;
    data_d     = data_q;
    valid_d    = valid_q;
    last_d     = last_q;
    sent_d     = sent_q;
    mem_we     = 1'b0;
    accept     = s_axis_tvalid & tready_q;
    handshake  = valid_q & blk_xfer_in_data_ready;
    case (state_q)
      S_FILL: begin
        if (accept) begin
          mem_we     = 1'b1;
          wr_cnt_d   = wr_cnt_q + CW'(1);
          idle_cnt_d = '0;
          // tlast wins over a simultaneous buffer-full condition
          if ((PACKET_MODE != 0) && s_axis_tlast) begin
            len_d      = wr_cnt_q + CW'(1);
            zlp_pend_d = (wr_cnt_q + CW'(1) == MAX_LEN);
            state_d    = S_HOLD;
          end else if (wr_cnt_q + CW'(1) == MAX_LEN) begin
            len_d      = MAX_LEN;
            zlp_pend_d = 1'b0;
            state_d    = S_HOLD;
          end else begin
            state_d = S_FILL;
          end
        end else if ((wr_cnt_q != '0) && (FLUSH_CYCLES != 0)) begin
          if (idle_cnt_q == IDLE_LAST) begin
            len_d      = wr_cnt_q;
            zlp_pend_d = 1'b0;
            idle_cnt_d = '0;
            state_d    = S_HOLD;
          end else begin
            idle_cnt_d = idle_cnt_q + IW'(1);
          end
        end else begin
          idle_cnt_d = '0;
        end
      end
      S_HOLD: begin
        if (blk_in_xfer) begin
          state_d  = S_SEND;
          rd_ptr_d = '0;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_SEND: begin
        if (!blk_in_xfer) begin
          rd_ptr_d = '0;
          valid_d  = 1'b0;
          last_d   = 1'b0;
          state_d  = S_HOLD;
        end else if (handshake && last_q) begin
          valid_d  = 1'b0;
          last_d   = 1'b0;
          sent_d   = sent_q + 16'd1;
          wr_cnt_d = '0;
          state_d  = zlp_pend_q ? S_ZLP_HOLD : S_FILL;
        end else if ((!valid_q || handshake) && (rd_ptr_q < len_q)) begin
          // output register doubles as the RAM read register: refill on every accept
          data_d   = mem[rd_ptr_q[AW-1:0]];
          valid_d  = 1'b1;
          last_d   = (rd_ptr_q == len_q - CW'(1));
          rd_ptr_d = rd_ptr_q + CW'(1);
        end else if (handshake) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else begin
          valid_d = valid_q;
        end
      end
      S_ZLP_HOLD: begin
        if (blk_in_xfer) begin
          valid_d = 1'b0;
          last_d  = 1'b1;
          state_d = S_ZLP_MARK;
        end else begin
          state_d = S_ZLP_HOLD;
        end
      end
      S_ZLP_MARK: begin
        last_d     = 1'b0;
        sent_d     = sent_q + 16'd1;
        zlp_pend_d = 1'b0;
        state_d    = S_FILL;
      end
      default: begin
        state_d = S_FILL;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
    tready_d   = (state_d == S_FILL) && (wr_cnt_d < MAX_LEN);
    has_data_d = (state_d != S_FILL);
  end

  // Packet buffer write port
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_cnt_q[AW-1:0]] <= s_axis_tdata;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FILL;
      wr_cnt_q   <= '0;
      len_q      <= '0;
      rd_ptr_q   <= '0;
      zlp_pend_q <= 1'b0;
      idle_cnt_q <= '0;
      tready_q   <= 1'b0;
      has_data_q <= 1'b0;
      data_q     <= 8'd0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      sent_q     <= 16'd0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      len_q      <= len_d;
      rd_ptr_q   <= rd_ptr_d;
      zlp_pend_q <= zlp_pend_d;
      idle_cnt_q <= idle_cnt_d;
      tready_q   <= tready_d;
      has_data_q <= has_data_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      sent_q     <= sent_d;
    end
  end

  assign s_axis_tready          = tready_q;
  assign blk_xfer_in_has_data   = has_data_q;
  assign blk_xfer_in_data       = data_q;
  assign blk_xfer_in_data_valid = valid_q;
  assign blk_xfer_in_data_last  = last_q;
  assign sent_packets           = sent_q;

endmodule

// File: doc/bulk_in_packetizer.md
Name: bulk_in_packetizer

Overview:
- Single-clock IN-direction packetizer in the USB clock domain, between an AXI-Stream byte source and the TLP bulk-IN transfer interface.
- Buffers one USB packet (up to MAX_PACKET bytes) and advertises has_data when the packet is ready.
- Streams the packet when the host's IN transfer is granted; rewinds and replays it if the transfer aborts.
- Inserts zero-length packets (ZLP) and flushes partially filled packets after an idle timeout.

Parameters:
- MAX_PACKET, 512, USB max packet size in bytes (512 HS, 64 FS); power of two, 8..512.
- PACKET_MODE, 1, 1: tlast closes a packet and a ZLP follows any frame whose length is a multiple of MAX_PACKET; 0: tlast ignored.
- FLUSH_CYCLES, 1024, idle clocks in FILL with a non-empty buffer before a short packet is forced out; 0 disables the flush.

Ports:
- clk  in  1  USB clock (60 MHz ULPI-derived).
- rst  in  1  asynchronous active-high reset.
- s_axis_tvalid  in  1  source byte valid.
- s_axis_tready  out  1  source byte ready.
- s_axis_tdata  in  8  source byte.
- s_axis_tlast  in  1  end of source frame.
- blk_in_xfer  in  1  IN transfer granted by TLP; high for the duration of the transfer.
- blk_xfer_in_has_data  out  1  packet or ZLP pending.
- blk_xfer_in_data  out  8  packet byte.
- blk_xfer_in_data_valid  out  1  byte valid.
- blk_xfer_in_data_ready  in  1  TLP accepts byte.
- blk_xfer_in_data_last  out  1  final byte of packet, or ZLP marker.
- sent_packets  out  16  count of completed packets including ZLPs; wraps.

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-high.
  - Reset forces state=FILL, wr_cnt=0, len=0, rd_ptr=0, zlp_pend=0, idle_cnt=0, sent_packets=0.
  - All outputs are 0 during reset, including s_axis_tready.
  - Reset mid-transfer discards buffered data.
- Storage: MAX_PACKET x 8 RAM; wr_cnt and len are clog2(MAX_PACKET)+1 bits wide.
- FILL state:
  - s_axis_tready=1 while wr_cnt<MAX_PACKET. Each accepted beat writes mem[wr_cnt] and increments wr_cnt; idle_cnt resets to 0.
  - PACKET_MODE=1 and tlast accepted: len=wr_cnt+1, zlp_pend=(len==MAX_PACKET), go to HOLD.
  - Otherwise, when the accepted beat makes wr_cnt+1==MAX_PACKET: len=MAX_PACKET, zlp_pend=0, go to HOLD.
  - When wr_cnt>0, no beat is accepted and FLUSH_CYCLES!=0: idle_cnt increments; when idle_cnt reaches FLUSH_CYCLES-1, len=wr_cnt and go to HOLD.
  - has_data=0 in FILL.
- HOLD state:
  - s_axis_tready=0; has_data=1 (registered, asserted the cycle after entry).
  - On blk_in_xfer=1, go to SEND with rd_ptr=0.
- SEND state:
  - data_valid first asserts within 2 clocks of blk_in_xfer rising; data=mem[rd_ptr]. The RAM read is prefetched so that, once data_ready is held high, a new byte is presented every clock.
  - data_last=1 exactly when rd_ptr==len-1.
  - data must stay stable while valid=1 and ready=0.
  - When the last byte handshakes: sent_packets increments and wr_cnt=0. If zlp_pend, go to ZLP_HOLD; otherwise go to FILL.
  - has_data deasserts in the cycle after the last handshake.
- ZLP_HOLD state:
  - has_data=1. On blk_in_xfer, present data_valid=0 and data_last=1 for exactly one cycle.
  - Then sent_packets increments, zlp_pend=0, go to FILL.
- Abort:
  - If blk_in_xfer falls in SEND before the last handshake, rd_ptr=0 and go to HOLD; the buffer contents are retained and replayed.
  - If blk_in_xfer falls in ZLP_HOLD before the marker cycle, remain in ZLP_HOLD.
- Simultaneous events:
  - A tlast on the beat that fills the buffer (wr_cnt+1==MAX_PACKET) is treated as tlast; zlp_pend follows PACKET_MODE.
  - blk_in_xfer while in FILL is ignored, with no data driven.

Test Plan:
- PACKET_MODE=1, MAX_PACKET=512: 10-byte frame with tlast, then blk_in_xfer with ready held 1 -> has_data=1, bytes 0..9 emitted in order on consecutive cycles, last on byte 9, sent_packets=1, has_data=0 afterwards.
- 1024-byte frame with tlast on byte 1023 -> two 512-byte packets, then a ZLP marker cycle (valid=0, last=1), sent_packets=3.
- PACKET_MODE=0, FLUSH_CYCLES=16: 5 bytes then source idle -> has_data asserts 16 clocks after the last beat, and a 5-byte packet is sent when blk_in_xfer is applied.
- Drop blk_in_xfer after 100 of 512 bytes, then re-grant -> all 512 bytes replayed starting from byte 0; sent_packets increments once.
- Random ready throttling (50%) over a 300-byte frame -> data held stable while stalled, byte sequence intact, s_axis_tready=0 throughout SEND.
- Assert rst during SEND -> all outputs 0 immediately; after release, state=FILL, tready=1, sent_packets=0.
